of_stage_pipe: RTL and testbench
================================

# of_stage_pipe

Pipelined, parametrised SimpleRISC operand-fetch stage. It decodes the 32-bit instruction (opcode, I bit, immx, branch target, register read addresses) and reads both operands from the register file. It interlocks read-after-write hazards with a per-register busy scoreboard and presents the result to EX through a registered valid/ready slice. It sits between the IF/decode latch and the EX stage; EX supplies flush and writeback-retire events.

## Interface
- `DATA_W`, 32: width of pc, register data, immx and branchTarget. Must be ≥ 32.
- `RA_IDX`, 15: register index used for `ret` reads and for call-style link writes.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  DATA_W  pc of instruction
- in_inst  in  32  instruction word
- in_isRet, in_isSt  in  1 each  read-port select controls
- in_isWb  in  1  instruction writes a register
- in_wbRa  in  1  destination is RA_IDX instead of inst[25:22]
- rf_rd1_addr, rf_rd2_addr  out  4 each  register-file read addresses (combinational from in_inst)
- rf_rd1_data, rf_rd2_data  in  DATA_W each  combinational read data
- wb_valid  in  1  a register write retires this cycle
- wb_addr  in  4  register retired
- flush  in  1  kill instruction held in the stage
- out_valid  out  1  EX-side valid
- out_ready  in  1  EX accepts
- out_pc, out_immx, out_branchTarget, out_op1, out_op2  out  DATA_W each
- out_opcode  out  5
- out_I  out  1
- out_rd  out  4
- out_wb  out  1

## Operation
- Decode (combinational on in_inst):
  - opcode = inst[31:27]; I = inst[26].
  - Modifier = inst[17:16].
    - 01 ('u'): immx = zero-extend inst[15:0].
    - 10 ('h'): immx = {inst[15:0], 16'b0}, then sign-extended from bit 31.
    - 00/11: immx = sign-extend inst[15:0].
  - branchTarget = pc + sign-extend(inst[26:0] << 2) from bit 28, modulo 2^DATA_W.
  - rf_rd1_addr = isRet ? RA_IDX : inst[21:18].
  - rf_rd2_addr = isSt ? inst[25:22] : inst[17:14].
- Source use:
  - Port 1 is always used.
  - Port 2 is used when I=0 or isSt=1.
- Hazard:
  - A used source address has a hazard when busy[addr] is set.
  - It also has a hazard when out_valid & out_wb & out_rd == addr.
- in_ready = !rst & !flush & !hazard & (!out_valid | out_ready).
- Accept (in_valid & in_ready):
  - Next cycle, the output register loads all decode fields plus op1/op2 from rf data, and out_valid=1.
  - out_rd = wbRa ? RA_IDX : inst[25:22]; out_wb = isWb.
- Issue (out_valid & out_ready & !flush):
  - Sets busy[out_rd] when out_wb = 1.
  - out_valid drops unless a new accept occurs in the same cycle.
- Retire: wb_valid clears busy[wb_addr]. If a set and a clear hit the same register in one cycle, the set wins.
- Stall: while out_valid & !out_ready, all out_* hold stable.
- Flush:
  - out_valid = 0 next cycle.
  - The killed instruction never sets busy.
  - No accept occurs in a flush cycle.
  - Busy bits are not altered by flush; older in-flight writes still retire.
- No writeback bypass: a consumer waits until busy is clear in the register state.

## Timing
- Reset: out_valid=0, busy=all zero, all out_* data=0. in_ready=0 during reset. Reset mid-operation discards held instruction and all pending busy bits.
- Latency: 1 cycle accept → out_valid.
- Throughput: 1 instruction per cycle with out_ready=1 and no hazard.
- RAW spacing: a consumer of register r becomes acceptable in the cycle after the wb_valid for r.
- Simultaneous flush and out_ready: flush wins; no issue, no busy set.
- Simultaneous issue and accept: accepted entry replaces issued entry; out_valid stays 1.

## Structure
- Shared package `simplerisc_pkg`:
  - INST_W=32, OPC_W=5, REG_AW=4.
  - Field bit positions.
  - Modifier encodings MOD_U=2'b01, MOD_H=2'b10.
  - Default RA_IDX.
- Sub-module `of_decode`: purely combinational immx / branchTarget / port-address logic, parametrised by DATA_W and RA_IDX.
- Top holds the scoreboard, hazard logic and output register.

## Test plan
- Store: pc=0, inst=0x7E080014, isSt=1 → rf_rd1_addr=2, rf_rd2_addr=8, out_immx=0x14, out_opcode=0x0F, out_I=1 one cycle after accept.
- 'h' immediate: inst=0x1486000F → out_immx=0x000F0000; with DATA_W=64 → 0x00000000000F0000.
- Branch: pc=0x100, inst=0x97FFFFFF → out_branchTarget=0xFC.
- RAW interlock:
  - Issue an instruction that writes r3 (in_isWb=1).
  - Next, present `sub` with rs1=3: in_ready=0.
  - Pulse wb_valid, wb_addr=3: in_ready=1 the following cycle.
- Backpressure plus flush:
  - Hold out_ready=0 for 3 cycles: outputs stable.
  - Assert flush: out_valid=0 next cycle, busy unchanged.
- Reset mid-stall: assert rst with busy[5]=1 and out_valid=1 → next cycle out_valid=0, busy all clear.

Source files
------------

// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg
// Shared constants and types for the SimpleRISC operand-fetch slice.
// Holds instruction field positions, the immediate modifier encodings and
// the default link register index used by the decode and pipe modules.
// No ports; imported with "import simplerisc_pkg::*".
package simplerisc_pkg;

  localparam int INST_W = 32;
  localparam int OPC_W  = 5;
  localparam int REG_AW = 4;

  // Instruction field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int I_BIT   = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 22;
  localparam int RS1_MSB = 21;
  localparam int RS1_LSB = 18;
  localparam int RS2_MSB = 17;
  localparam int RS2_LSB = 14;
  localparam int MOD_MSB = 17;
  localparam int MOD_LSB = 16;
  localparam int IMM_MSB = 15;
  localparam int OFF_MSB = 26;

  // Return-address register used by ret reads and call-style link writes
  localparam int DEFAULT_RA_IDX = 15;

  // Immediate modifier encodings; both unnamed codes mean sign-extend
  typedef enum logic [1:0] {
    MOD_S  = 2'b00,
    MOD_U  = 2'b01,
    MOD_H  = 2'b10,
    MOD_S3 = 2'b11
  } modifier_e;

endpackage

// File: rtl/of_stage_pipe_if.sv
// of_stage_pipe_if
// Bundles every non-clock signal of the operand-fetch stage: the upstream
// valid/ready handshake with instruction controls, the register-file read
// ports, the writeback-retire and flush events from EX, and the EX-side
// valid/ready output slice.
// Modports: slave = the operand-fetch stage, master = its surroundings.
interface of_stage_pipe_if #(
  parameter int DATA_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pc;
  logic [31:0]       in_inst;
  logic              in_isRet;
  logic              in_isSt;
  logic              in_isWb;
  logic              in_wbRa;

  logic [3:0]        rf_rd1_addr;
  logic [3:0]        rf_rd2_addr;
  logic [DATA_W-1:0] rf_rd1_data;
  logic [DATA_W-1:0] rf_rd2_data;

  logic              wb_valid;
  logic [3:0]        wb_addr;
  logic              flush;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_immx;
  logic [DATA_W-1:0] out_branchTarget;
  logic [DATA_W-1:0] out_op1;
  logic [DATA_W-1:0] out_op2;
  logic [4:0]        out_opcode;
  logic              out_I;
  logic [3:0]        out_rd;
  logic              out_wb;

  modport slave (
    input  in_valid, in_pc, in_inst, in_isRet, in_isSt, in_isWb, in_wbRa,
    output in_ready,
    output rf_rd1_addr, rf_rd2_addr,
    input  rf_rd1_data, rf_rd2_data,
    input  wb_valid, wb_addr, flush,
    output out_valid,
    input  out_ready,
    output out_pc, out_immx, out_branchTarget, out_op1, out_op2,
    output out_opcode, out_I, out_rd, out_wb
  );

  modport master (
    output in_valid, in_pc, in_inst, in_isRet, in_isSt, in_isWb, in_wbRa,
    input  in_ready,
    input  rf_rd1_addr, rf_rd2_addr,
    output rf_rd1_data, rf_rd2_data,
    output wb_valid, wb_addr, flush,
    input  out_valid,
    output out_ready,
    input  out_pc, out_immx, out_branchTarget, out_op1, out_op2,
    input  out_opcode, out_I, out_rd, out_wb
  );

endinterface

// File: rtl/of_decode.sv
// of_decode
// Purely combinational SimpleRISC instruction decode.
// Ports:
//   pc_i, inst_i                 pc and instruction word
//   isRet_i, isSt_i, wbRa_i      read-port / destination select controls
//   opcode_o, iBit_o             opcode and immediate flag
//   immx_o, branchTarget_o       extended immediate and pc-relative target
//   rd1Addr_o, rd2Addr_o         register-file read addresses
//   rd_o                         destination register
//   useRs2_o                     second read port carries a real source
module of_decode import simplerisc_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int RA_IDX = DEFAULT_RA_IDX
) (
  input  logic [DATA_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              isRet_i,
  input  logic              isSt_i,
  input  logic              wbRa_i,
  output logic [OPC_W-1:0]  opcode_o,
  output logic              iBit_o,
  output logic [DATA_W-1:0] immx_o,
  output logic [DATA_W-1:0] branchTarget_o,
  output logic [REG_AW-1:0] rd1Addr_o,
  output logic [REG_AW-1:0] rd2Addr_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              useRs2_o
);

  logic [15:0]       imm16;
  logic [DATA_W-1:0] offset;

  assign imm16 = inst_i[IMM_MSB:0];

  // The 'h' form places imm16 in the upper half of a 32-bit word, so for
  // wider datapaths its bit 15 also becomes the sign of the full value.
  always_comb begin
    immx_o = {DATA_W{imm16[15]}};
    case (modifier_e'(inst_i[MOD_MSB:MOD_LSB]))
      MOD_U: begin
        immx_o        = {DATA_W{1'b0}};
        immx_o[15:0]  = imm16;
      end
      MOD_H: begin
        immx_o[31:16] = imm16;
        immx_o[15:0]  = 16'h0000;
      end
      default: begin
        immx_o[15:0]  = imm16;
      end
    endcase
  end

  // Word offset scaled to bytes; bit 28 of the scaled value is the sign.
  always_comb begin
    offset                = {DATA_W{inst_i[OFF_MSB]}};
    offset[OFF_MSB+2:0]   = {inst_i[OFF_MSB:0], 2'b00};
    branchTarget_o        = pc_i + offset;
  end

  assign opcode_o  = inst_i[OPC_MSB:OPC_LSB];
  assign iBit_o    = inst_i[I_BIT];
  assign rd1Addr_o = isRet_i ? REG_AW'(RA_IDX) : inst_i[RS1_MSB:RS1_LSB];
  assign rd2Addr_o = isSt_i ? inst_i[RD_MSB:RD_LSB] : inst_i[RS2_MSB:RS2_LSB];
  assign rd_o      = wbRa_i ? REG_AW'(RA_IDX) : inst_i[RD_MSB:RD_LSB];
  // Stores read their data register through port 2 even in immediate form
  assign useRs2_o  = !inst_i[I_BIT] || isSt_i;

endmodule

// File: rtl/of_stage_pipe.sv
// of_stage_pipe
// SimpleRISC operand-fetch stage: decodes the instruction, reads both
// operands, interlocks read-after-write hazards with a per-register busy
// scoreboard and hands the result to EX through a registered valid/ready
// slice.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   of_stage_pipe_if.slave: upstream handshake, register-file reads,
//         writeback retire, flush and the EX-side output slice
module of_stage_pipe import simplerisc_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int RA_IDX = DEFAULT_RA_IDX
) (
  input  logic        clk,
  input  logic        rst,
  of_stage_pipe_if.slave bus
);

  logic [OPC_W-1:0]  decOpcode;
  logic              decI;
  logic [DATA_W-1:0] decImmx;
  logic [DATA_W-1:0] decTarget;
  logic [REG_AW-1:0] decRd1;
  logic [REG_AW-1:0] decRd2;
  logic [REG_AW-1:0] decRd;
  logic              decUseRs2;

  logic              hit1;
  logic              hit2;
  logic              inReady;
  logic              accept;
  logic              issue;

  logic [15:0]       busy_q,      busy_d;
  logic              outValid_q,  outValid_d;
  logic [DATA_W-1:0] outPc_q,     outPc_d;
  logic [DATA_W-1:0] outImmx_q,   outImmx_d;
  logic [DATA_W-1:0] outTarget_q, outTarget_d;
  logic [DATA_W-1:0] outOp1_q,    outOp1_d;
  logic [DATA_W-1:0] outOp2_q,    outOp2_d;
  logic [OPC_W-1:0]  outOpcode_q, outOpcode_d;
  logic              outI_q,      outI_d;
  logic [REG_AW-1:0] outRd_q,     outRd_d;
  logic              outWb_q,     outWb_d;

  of_decode #(
    .DATA_W (DATA_W),
    .RA_IDX (RA_IDX)
  ) u_decode (
    .pc_i           (bus.in_pc),
    .inst_i         (bus.in_inst),
    .isRet_i        (bus.in_isRet),
    .isSt_i         (bus.in_isSt),
    .wbRa_i         (bus.in_wbRa),
    .opcode_o       (decOpcode),
    .iBit_o         (decI),
    .immx_o         (decImmx),
    .branchTarget_o (decTarget),
    .rd1Addr_o      (decRd1),
    .rd2Addr_o      (decRd2),
    .rd_o           (decRd),
    .useRs2_o       (decUseRs2)
  );

  assign bus.rf_rd1_addr = decRd1;
  assign bus.rf_rd2_addr = decRd2;

  // A source is blocked by a retired-pending write in the scoreboard or by
  // the writer still sitting in the output register (not yet in busy).
  always_comb begin
    hit1    = busy_q[decRd1] || (outValid_q && outWb_q && (outRd_q == decRd1));
    hit2    = busy_q[decRd2] || (outValid_q && outWb_q && (outRd_q == decRd2));
    inReady = !rst && !bus.flush && !hit1 && !(decUseRs2 && hit2)
              && (!outValid_q || bus.out_ready);
    accept  = bus.in_valid && inReady;
    issue   = outValid_q && bus.out_ready && !bus.flush;
  end

  assign bus.in_ready = inReady;

  // Retire clears first so an issue to the same register in the same cycle
  // leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid) begin
      busy_d[bus.wb_addr] = 1'b0;
    end
    if (issue && outWb_q) begin
      busy_d[outRd_q] = 1'b1;
    end
  end

  // Output slice: data only changes on accept, so a stalled entry holds.
  always_comb begin
    outValid_d  = outValid_q;
    outPc_d     = outPc_q;
    outImmx_d   = outImmx_q;
    outTarget_d = outTarget_q;
    outOp1_d    = outOp1_q;
    outOp2_d    = outOp2_q;
    outOpcode_d = outOpcode_q;
    outI_d      = outI_q;
    outRd_d     = outRd_q;
    outWb_d     = outWb_q;
    if (accept) begin
      outValid_d  = 1'b1;
      outPc_d     = bus.in_pc;
      outImmx_d   = decImmx;
      outTarget_d = decTarget;
      outOp1_d    = bus.rf_rd1_data;
      outOp2_d    = bus.rf_rd2_data;
      outOpcode_d = decOpcode;
      outI_d      = decI;
      outRd_d     = decRd;
      outWb_d     = bus.in_isWb;
    end else if (bus.flush || issue) begin
      outValid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      outValid_q  <= 1'b0;
      outPc_q     <= '0;
      outImmx_q   <= '0;
      outTarget_q <= '0;
      outOp1_q    <= '0;
      outOp2_q    <= '0;
      outOpcode_q <= '0;
      outI_q      <= 1'b0;
      outRd_q     <= '0;
      outWb_q     <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      outValid_q  <= outValid_d;
      outPc_q     <= outPc_d;
      outImmx_q   <= outImmx_d;
      outTarget_q <= outTarget_d;
      outOp1_q    <= outOp1_d;
      outOp2_q    <= outOp2_d;
      outOpcode_q <= outOpcode_d;
      outI_q      <= outI_d;
      outRd_q     <= outRd_d;
      outWb_q     <= outWb_d;
    end
  end

  assign bus.out_valid        = outValid_q;
  assign bus.out_pc           = outPc_q;
  assign bus.out_immx         = outImmx_q;
  assign bus.out_branchTarget = outTarget_q;
  assign bus.out_op1          = outOp1_q;
  assign bus.out_op2          = outOp2_q;
  assign bus.out_opcode       = outOpcode_q;
  assign bus.out_I            = outI_q;
  assign bus.out_rd           = outRd_q;
  assign bus.out_wb           = outWb_q;

endmodule

// File: tb/tb_of_stage_pipe.sv
// tb_of_stage_pipe
// Directed scenarios followed by randomized traffic for of_stage_pipe,
// compared each cycle against a transaction-level reference model.
module tb_of_stage_pipe;

  logic clk = 1'b0;
  logic rst;

  // Clock generation
  always #5 clk = ~clk;

  of_stage_pipe_if #(.DATA_W(32)) bus ();

  of_stage_pipe #(
    .DATA_W (32),
    .RA_IDX (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural register file feeding the combinational read ports
  logic [31:0] rfMem [16];
  assign bus.rf_rd1_data = rfMem[bus.rf_rd1_addr];
  assign bus.rf_rd2_data = rfMem[bus.rf_rd2_addr];

  // Reference model state: the instruction waiting for EX and the set of
  // registers whose writes have gone to EX but not yet retired.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] immx;
    logic [31:0] target;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  opcode;
    logic        iBit;
    logic [3:0]  rd;
    logic        wb;
  } entry_t;

  entry_t      held;
  logic [15:0] pending;
  int          errorCount = 0;
  int          checkCount = 0;

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives every stage input for the coming cycle
  task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] pc,
                               input logic [31:0] inst, input logic isRet,
                               input logic isSt, input logic isWb, input logic wbRa,
                               input logic wbV, input logic [3:0] wbA,
                               input logic fl, input logic ordy);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.in_isRet  = isRet;
    bus.in_isSt   = isSt;
    bus.in_isWb   = isWb;
    bus.in_wbRa   = wbRa;
    bus.wb_valid  = wbV;
    bus.wb_addr   = wbA;
    bus.flush     = fl;
    bus.out_ready = ordy;
  endtask

  function automatic logic [31:0] refImmx(input logic [31:0] inst);
    int low;
    low = int'(inst & 32'h0000FFFF);
    case (inst[17:16])
      2'b01:   return 32'(low);
      2'b10:   return 32'(low * 65536);
      default: return (low >= 32768) ? 32'(low - 65536) : 32'(low);
    endcase
  endfunction

  function automatic logic [31:0] refTarget(input logic [31:0] pc, input logic [31:0] inst);
    int words;
    words = int'(inst & 32'h07FFFFFF);
    if (words >= (1 << 26)) words = words - (1 << 27);
    return pc + 32'(words * 4);
  endfunction

  function automatic logic [3:0] refRd1(input logic [31:0] inst, input logic isRet);
    return isRet ? 4'd15 : 4'((inst >> 18) & 32'hF);
  endfunction

  function automatic logic [3:0] refRd2(input logic [31:0] inst, input logic isSt);
    return isSt ? 4'((inst >> 22) & 32'hF) : 4'((inst >> 14) & 32'hF);
  endfunction

  function automatic logic srcBlocked(input logic [3:0] a);
    return pending[a] || (held.valid && held.wb && held.rd == a);
  endfunction

  // Checks the DUT against the model for the current cycle, then advances
  // the model across the next rising edge.
  task automatic stepCycle();
    logic [3:0]  a1, a2, dst;
    logic        use2, expReady, issue;
    logic [15:0] nextPending;
    #1;
    a1       = refRd1(bus.in_inst, bus.in_isRet);
    a2       = refRd2(bus.in_inst, bus.in_isSt);
    use2     = !bus.in_inst[26] || bus.in_isSt;
    expReady = !rst && !bus.flush && !srcBlocked(a1) && !(use2 && srcBlocked(a2))
               && (!held.valid || bus.out_ready);
    checkOutput("in_ready", bus.in_ready, expReady);
    checkOutput("rd1_addr", bus.rf_rd1_addr, a1);
    checkOutput("rd2_addr", bus.rf_rd2_addr, a2);
    checkOutput("out_valid", bus.out_valid, held.valid);
    if (held.valid) begin
      checkOutput("out_pc", bus.out_pc, held.pc);
      checkOutput("out_immx", bus.out_immx, held.immx);
      checkOutput("out_target", bus.out_branchTarget, held.target);
      checkOutput("out_op1", bus.out_op1, held.op1);
      checkOutput("out_op2", bus.out_op2, held.op2);
      checkOutput("out_opcode", bus.out_opcode, held.opcode);
      checkOutput("out_I", bus.out_I, held.iBit);
      checkOutput("out_rd", bus.out_rd, held.rd);
      checkOutput("out_wb", bus.out_wb, held.wb);
    end
    if (rst) begin
      held    = '0;
      pending = '0;
    end else begin
      issue       = held.valid && bus.out_ready && !bus.flush;
      nextPending = pending;
      if (bus.wb_valid) nextPending[bus.wb_addr] = 1'b0;
      if (issue && held.wb) nextPending[held.rd] = 1'b1;
      pending = nextPending;
      if (bus.in_valid && expReady) begin
        dst         = bus.in_wbRa ? 4'd15 : 4'((bus.in_inst >> 22) & 32'hF);
        held.valid  = 1'b1;
        held.pc     = bus.in_pc;
        held.immx   = refImmx(bus.in_inst);
        held.target = refTarget(bus.in_pc, bus.in_inst);
        held.op1    = rfMem[a1];
        held.op2    = rfMem[a2];
        held.opcode = 5'(bus.in_inst >> 27);
        held.iBit   = bus.in_inst[26];
        held.rd     = dst;
        held.wb     = bus.in_isWb;
      end else if (bus.flush || issue) begin
        held.valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] wa;
    for (int i = 0; i < 16; i++) rfMem[i] = $urandom;
    held    = '0;
    pending = '0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset holds the stage closed even with a valid instruction offered
    applyStimulus(1, 1, 0, 32'h7E080014, 0, 1, 0, 0, 0, 0, 0, 1);
    stepCycle();
    checkOutput("rst_out_immx", bus.out_immx, 0);
    checkOutput("rst_out_pc", bus.out_pc, 0);
    checkOutput("rst_out_op1", bus.out_op1, 0);

    // Store with EX stalled
    applyStimulus(0, 1, 0, 32'h7E080014, 0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("store_rd1", bus.rf_rd1_addr, 2);
    checkOutput("store_rd2", bus.rf_rd2_addr, 8);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("store_valid", bus.out_valid, 1);
    checkOutput("store_immx", bus.out_immx, 32'h14);
    checkOutput("store_opcode", bus.out_opcode, 5'h0F);
    checkOutput("store_I", bus.out_I, 1);
    stepCycle();

    // 'h' immediate, then a back-to-back branch
    applyStimulus(0, 1, 0, 32'h1486000F, 0, 0, 0, 0, 0, 0, 0, 1);
    stepCycle();
    checkOutput("h_immx", bus.out_immx, 32'h000F0000);
    applyStimulus(0, 1, 32'h100, 32'h97FFFFFF, 0, 0, 0, 0, 0, 0, 0, 1);
    stepCycle();
    checkOutput("branch_target", bus.out_branchTarget, 32'hFC);

    // RAW interlock on r3
    applyStimulus(0, 1, 0, 32'h04C00000, 0, 0, 1, 0, 0, 0, 0, 1);
    stepCycle();
    applyStimulus(0, 1, 0, 32'h0C0C0000, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("raw_held_writer", bus.in_ready, 0);
    stepCycle();
    #1;
    checkOutput("raw_busy", bus.in_ready, 0);
    stepCycle();
    applyStimulus(0, 1, 0, 32'h0C0C0000, 0, 0, 0, 0, 1, 3, 0, 1);
    #1;
    checkOutput("raw_wb_cycle", bus.in_ready, 0);
    stepCycle();
    applyStimulus(0, 1, 0, 32'h0C0C0000, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("raw_release", bus.in_ready, 1);
    stepCycle();

    // Backpressure on a writer of r5, then flush it
    applyStimulus(0, 1, 32'h200, 32'h05400000, 0, 0, 1, 0, 0, 0, 0, 1);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("stall_pc", bus.out_pc, 32'h200);
      stepCycle();
    end
    applyStimulus(0, 1, 0, 32'h0C140000, 0, 0, 0, 0, 0, 0, 1, 1);
    stepCycle();
    checkOutput("flush_valid", bus.out_valid, 0);
    applyStimulus(0, 1, 0, 32'h0C140000, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("flush_no_busy", bus.in_ready, 1);
    stepCycle();

    // Reset while r5 is pending and an entry is stalled
    applyStimulus(0, 1, 32'h300, 32'h05400000, 0, 0, 1, 0, 0, 0, 0, 1);
    stepCycle();
    applyStimulus(0, 1, 32'h304, 32'h04000000, 0, 0, 0, 0, 0, 0, 0, 1);
    stepCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("rst_mid_valid", bus.out_valid, 0);
    applyStimulus(0, 1, 0, 32'h0C140000, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("rst_mid_busy", bus.in_ready, 1);
    stepCycle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) rfMem[$urandom_range(0, 15)] = $urandom;
      wa = 4'($urandom_range(0, 15));
      if (pending != 0) begin
        for (int t = 0; t < 16 && !pending[wa]; t++) wa = 4'($urandom_range(0, 15));
      end
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                    $urandom, $urandom,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 9) < 3, wa,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
      stepCycle();
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
